toggle_pulse_gen: RTL and testbench
===================================

Name: toggle_pulse_gen

Overview:
- Upstream stage for the counter's toggle flip-flop chain: turns a raw, bouncy push-button level into a clean single-cycle toggle-enable pulse (t_pulse) that drives the first T stage's T input.
- Contains a 2-FF synchronizer, a debounce counter/FSM and a wrapping press counter.
- Runs on posedge clk, so t_pulse is stable across the downstream negedge-clocked T stage's sampling edge. Each pulse gives exactly one toggle.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a press or release; legal range >=1.
- CNT_W, 8, width of pulse_cnt.
- REPEAT_DELAY, 16, cycles in HELD before the first auto-repeat pulse; used only with TOGGLE_AUTOREPEAT_EN.
- REPEAT_PERIOD, 8, cycles between subsequent auto-repeat pulses; used only with TOGGLE_AUTOREPEAT_EN.

Ports:
- clk  input  1  clock, rising-edge active.
- rstn  input  1  reset, asynchronous, active-low.
- btn_in  input  1  raw button, active-high, asynchronous to clk.
- enable  input  1  when 0, suppresses t_pulse and pulse_cnt increments; debounce tracking continues.
- t_pulse  output  1  registered one-cycle toggle enable for the downstream T stage.
- btn_level  output  1  registered debounced button level.
- pulse_cnt  output  CNT_W  number of t_pulse assertions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rstn=0):
  - sync FFs=0, state=IDLE, debounce counter=0.
  - t_pulse=0, btn_level=0, pulse_cnt=0.
  - Applies immediately mid-operation; any press in progress is discarded.
- Synchronizer: s1<=btn_in, s2<=s1. The FSM sees only s2.
- FSM states and transitions:
  - IDLE: s2=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: s2=0 -> IDLE (glitch rejected, no pulse). Else if cnt==DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, t_pulse<=enable. Else cnt++.
  - HELD: s2=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT: s2=1 -> HELD (bounce, no pulse, btn_level stays 1). Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0. Else cnt++.
- Latency: counting posedge #1 as the first edge that samples btn_in=1, t_pulse and btn_level rise at edge DEBOUNCE_CYCLES+3 (edge 7 for the default). Release is symmetric: btn_level falls at edge DEBOUNCE_CYCLES+3 after the first low sample.
- t_pulse is high for exactly one clock period (posedge to posedge), then returns to 0. Never two consecutive cycles without the optional feature.
- pulse_cnt increments in the same cycle t_pulse is registered high. 2^CNT_W-1 wraps to 0.
- enable sampled at the PRESS_WAIT->HELD transition only. enable=0 there means no pulse and no count; btn_level still follows the debounced level.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1); it never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro TOGGLE_AUTOREPEAT_EN.
- Defined: in HELD, a repeat counter runs.
  - At REPEAT_DELAY cycles after HELD entry, t_pulse<=enable for one cycle.
  - Thereafter one pulse every REPEAT_PERIOD cycles while HELD, each counted in pulse_cnt.
  - RELEASE_WAIT freezes the repeat counter; return to HELD resumes it; IDLE clears it.
- Undefined: exactly one pulse per accepted press; REPEAT_* parameters are ignored and the repeat logic is absent.

Test Plan:
- Reset: rstn=0 for 3 cycles with btn_in=1 -> t_pulse=0, btn_level=0, pulse_cnt=0. Deassert rstn with btn_in=1 held -> single pulse at edge 7 after release of reset. Assert rstn mid-PRESS_WAIT -> no pulse.
- Clean press (default params, enable=1), btn_in high 20 cycles -> one t_pulse at edge 7, btn_level 1 from edge 7, pulse_cnt=1. Release -> btn_level 0 at edge 7 after the first low sample.
- Glitch: btn_in high for 3 cycles then low -> t_pulse never asserts, btn_level stays 0, pulse_cnt=0.
- Release bounce: during hold, btn_in low for 2 cycles then high -> btn_level stays 1, no second pulse. enable=0 press -> btn_level toggles, pulse_cnt unchanged.
- Downstream: 3 presses with t_pulse driving the negedge T stage (Q reset 0) -> Q toggles exactly once per press (0->1->0->1). With CNT_W=2, 5 presses -> pulse_cnt=1 (wrap).
- TOGGLE_AUTOREPEAT_EN defined, REPEAT_DELAY=16, REPEAT_PERIOD=8, hold 40 cycles after HELD entry -> pulses at HELD+0, +16, +24, +32, +40; pulse_cnt=5.

Source files
------------

// File: rtl/toggle_pulse_gen.sv
// ---------------------------------------------------------------------------
// toggle_pulse_gen
//
// Front end for the toggle flip-flop counter chain. A raw, bouncy push-button
// level is synchronized into the clk domain, debounced by a small FSM, and
// turned into a clean single-cycle toggle enable (t_pulse) for the first
// negedge-clocked T stage. Because everything here is posedge-clocked,
// t_pulse is stable around the downstream stage's sampling edge, so each
// pulse yields exactly one toggle.
//
// Optional feature (compile-time macro):
//   TOGGLE_AUTOREPEAT_EN - while the button stays debounced-held, emit a
//   first repeat pulse REPEAT_DELAY cycles after the press was accepted and
//   then one pulse every REPEAT_PERIOD cycles. Without the macro exactly one
//   pulse is produced per accepted press and the REPEAT_* parameters only
//   take part in the parameter sanity check.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable synchronized cycles needed to accept
//                     a press or a release (>= 1)
//   CNT_W           - width of pulse_cnt
//   REPEAT_DELAY    - HELD cycles before the first auto-repeat pulse
//   REPEAT_PERIOD   - cycles between subsequent auto-repeat pulses
//
// Ports:
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   btn_in     in   raw button level, active-high, asynchronous to clk
//   enable     in   0 suppresses t_pulse and pulse_cnt increments; the
//                   debounce tracking and btn_level keep running
//   t_pulse    out  registered one-cycle toggle enable
//   btn_level  out  registered debounced button level
//   pulse_cnt  out  number of t_pulse assertions, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module toggle_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             btn_in,
    input  logic             enable,
    output logic             t_pulse,
    output logic             btn_level,
    output logic [CNT_W-1:0] pulse_cnt
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int                DBC_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBC_W-1:0]  DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

    // Reject nonsensical configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || CNT_W < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_bad_params
        $error("toggle_pulse_gen: DEBOUNCE_CYCLES, CNT_W, REPEAT_DELAY and REPEAT_PERIOD must all be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,  // released, waiting for a high sample
        PRESS_WAIT   = 2'd1,  // high seen, proving it stays high
        HELD         = 2'd2,  // press accepted
        RELEASE_WAIT = 2'd3   // low seen while held, proving it stays low
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    state_e           state_q, state_d;
    logic [DBC_W-1:0] dbc_q, dbc_d;
    logic             btn_level_q, btn_level_d;
    logic             t_pulse_q, t_pulse_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

`ifdef TOGGLE_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    // rpt_armed_q: 0 while waiting for the first (delayed) repeat,
    // 1 once the periodic phase has started.
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;
`endif

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= IDLE;
            dbc_q       <= '0;
            btn_level_q <= 1'b0;
            t_pulse_q   <= 1'b0;
            pulse_cnt_q <= '0;
`ifdef TOGGLE_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
`endif
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            state_q     <= state_d;
            dbc_q       <= dbc_d;
            btn_level_q <= btn_level_d;
            t_pulse_q   <= t_pulse_d;
            pulse_cnt_q <= pulse_cnt_d;
`ifdef TOGGLE_AUTOREPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        s1_d        = btn_in;
        s2_d        = s1_q;
        state_d     = state_q;
        dbc_d       = dbc_q;
        btn_level_d = btn_level_q;
        t_pulse_d   = 1'b0;          // pulse lasts one cycle unless re-fired
        pulse_cnt_d = pulse_cnt_q;
`ifdef TOGGLE_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;     // frozen unless HELD advances it
        rpt_armed_d = rpt_armed_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    dbc_d   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;                // glitch, no pulse
                end else if (dbc_q == DBC_LAST) begin
                    state_d     = HELD;
                    btn_level_d = 1'b1;
                    t_pulse_d   = enable;          // enable only matters here
                end else begin
                    dbc_d = dbc_q + DBC_W'(1);
                end
            end

            HELD: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    dbc_d   = '0;
                end
`ifdef TOGGLE_AUTOREPEAT_EN
                else begin
                    if (rpt_cnt_q == (rpt_armed_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                        t_pulse_d   = enable;
                        rpt_cnt_d   = '0;
                        rpt_armed_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
`endif
            end

            RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = HELD;                // release bounce, level stays 1
                end else if (dbc_q == DBC_LAST) begin
                    state_d     = IDLE;
                    btn_level_d = 1'b0;
                end else begin
                    dbc_d = dbc_q + DBC_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The count advances in the same cycle the pulse is registered.
        if (t_pulse_d) begin
            pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
        end

`ifdef TOGGLE_AUTOREPEAT_EN
        // Outside a held press the repeat timer restarts from scratch.
        if (state_q == IDLE || state_q == PRESS_WAIT) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end
`endif
    end

    assign t_pulse   = t_pulse_q;
    assign btn_level = btn_level_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
module tb_toggle_pulse_gen;

    localparam int D  = 4;
    localparam int CW = 8;
    localparam int RD = 16;
    localparam int RP = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          btn_in = 1'b0;
    logic          enable = 1'b1;
    logic          t_pulse, btn_level;
    logic [CW-1:0] pulse_cnt;
    logic          t_pulse_n, btn_level_n;
    logic [1:0]    pulse_cnt_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    toggle_pulse_gen #(
        .DEBOUNCE_CYCLES(D), .CNT_W(CW), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rstn(rstn), .btn_in(btn_in), .enable(enable),
        .t_pulse(t_pulse), .btn_level(btn_level), .pulse_cnt(pulse_cnt)
    );

    // Narrow counter instance for the wrap-around case.
    toggle_pulse_gen #(
        .DEBOUNCE_CYCLES(D), .CNT_W(2), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_narrow (
        .clk(clk), .rstn(rstn), .btn_in(btn_in), .enable(enable),
        .t_pulse(t_pulse_n), .btn_level(btn_level_n), .pulse_cnt(pulse_cnt_n)
    );

    // Downstream T stage: negedge-clocked, Q reset to 0.
    logic q;
    always @(negedge clk or negedge rstn) begin
        if (!rstn)        q <= 1'b0;
        else if (t_pulse) q <= ~q;
    end

    // ------------------------------------------------------------------
    // Reference model: the button level is accepted once the sample seen
    // two edges late has disagreed with the current level for D+1 edges
    // in a row; any agreeing sample restarts that run.
    // ------------------------------------------------------------------
    logic m_h0, m_h1, m_level, m_pulse;
    int   m_run, m_ticks, m_total;

    task automatic model_reset();
        m_h0 = 1'b0; m_h1 = 1'b0; m_level = 1'b0; m_pulse = 1'b0;
        m_run = 0; m_ticks = 0; m_total = 0;
    endtask

    task automatic model_edge(input logic b, input logic e);
        logic seen;
        seen = m_h1; m_h1 = m_h0; m_h0 = b;
        m_pulse = 1'b0;
        if (seen != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = seen; m_run = 0; m_ticks = 0;
                if (seen) m_pulse = e;
            end
        end else begin
`ifdef TOGGLE_AUTOREPEAT_EN
            if (m_level && m_run == 0) begin
                m_ticks++;
                if (m_ticks == RD || (m_ticks > RD && (m_ticks - RD) % RP == 0))
                    m_pulse = e;
            end
`endif
            m_run = 0;
        end
        if (m_pulse) m_total++;
    endtask

    // One clock: drive inputs, advance the model at the edge, settle 1ns.
    task automatic step(input logic b, input logic e);
        btn_in = b; enable = e;
        @(posedge clk);
        model_edge(b, e);
        #1;
    endtask

    task automatic settle();
        repeat (12) step(1'b0, 1'b1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [CW-1:0] exp_c;
        rstn = 1'b0; btn_in = 1'b1; enable = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (t_pulse !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== '0 || q !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got p=%b l=%b cnt=%0d q=%b, want all 0",
                         i, t_pulse, btn_level, pulse_cnt, q);
            end
        end
        rstn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1);
            exp_c = (i >= 7) ? CW'(1) : CW'(0);
            checks++;
            if (t_pulse !== (i == 7) || btn_level !== (i >= 7) || pulse_cnt !== exp_c) begin
                errors++;
                $display("FAIL reset_release edge %0d: got p=%b l=%b cnt=%0d, want p=%b l=%b cnt=%0d",
                         i, t_pulse, btn_level, pulse_cnt, (i == 7), (i >= 7), exp_c);
            end
        end
        // Reset while a press is still being debounced.
        settle();
        repeat (4) step(1'b1, 1'b1);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (t_pulse !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== '0) begin
            errors++;
            $display("FAIL reset_async: got p=%b l=%b cnt=%0d, want 0 0 0",
                     t_pulse, btn_level, pulse_cnt);
        end
        @(posedge clk); @(posedge clk); #1;
        btn_in = 1'b0; rstn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (t_pulse !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== '0) begin
                errors++;
                $display("FAIL reset_discard edge %0d: got p=%b l=%b cnt=%0d, want 0 0 0",
                         i, t_pulse, btn_level, pulse_cnt);
            end
        end
    endtask

    task automatic test_clean_press();
        int            base;
        logic [CW-1:0] exp_c;
        settle();
        base = m_total;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1);
            exp_c = CW'(base + ((i >= 7) ? 1 : 0));
            checks++;
            if (t_pulse !== (i == 7) || btn_level !== (i >= 7) || pulse_cnt !== exp_c) begin
                errors++;
                $display("FAIL clean_press edge %0d: got p=%b l=%b cnt=%0d, want p=%b l=%b cnt=%0d",
                         i, t_pulse, btn_level, pulse_cnt, (i == 7), (i >= 7), exp_c);
            end
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (t_pulse !== 1'b0 || btn_level !== (i < 7)) begin
                errors++;
                $display("FAIL clean_release edge %0d: got p=%b l=%b, want p=0 l=%b",
                         i, t_pulse, btn_level, (i < 7));
            end
        end
    endtask

    task automatic test_glitch();
        int            base;
        logic [CW-1:0] exp_c;
        settle();
        base  = m_total;
        exp_c = CW'(base);
        for (int i = 1; i <= 13; i++) begin
            step((i <= 3), 1'b1);
            checks++;
            if (t_pulse !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== exp_c) begin
                errors++;
                $display("FAIL glitch edge %0d: got p=%b l=%b cnt=%0d, want p=0 l=0 cnt=%0d",
                         i, t_pulse, btn_level, pulse_cnt, exp_c);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic b;
        settle();
        // 8 high, 2 low, 6 high: only the first acceptance pulses.
        for (int i = 1; i <= 16; i++) begin
            b = !(i == 9 || i == 10);
            step(b, 1'b1);
            checks++;
            if (t_pulse !== (i == 7) || btn_level !== (i >= 7)) begin
                errors++;
                $display("FAIL release_bounce edge %0d: got p=%b l=%b, want p=%b l=%b",
                         i, t_pulse, btn_level, (i == 7), (i >= 7));
            end
        end
        settle();
    endtask

    task automatic test_enable_off();
        int            base;
        logic [CW-1:0] exp_c;
        settle();
        base  = m_total;
        exp_c = CW'(base);
        for (int i = 1; i <= 22; i++) begin
            step((i <= 10), 1'b0);
            checks++;
            if (t_pulse !== 1'b0 || btn_level !== (i >= 7 && i < 17) || pulse_cnt !== exp_c) begin
                errors++;
                $display("FAIL enable_off edge %0d: got p=%b l=%b cnt=%0d, want p=0 l=%b cnt=%0d",
                         i, t_pulse, btn_level, pulse_cnt, (i >= 7 && i < 17), exp_c);
            end
        end
    endtask

    task automatic test_downstream_wrap();
        logic [CW-1:0] exp_c;
        logic [1:0]    exp_n;
        rstn = 1'b0; btn_in = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            repeat (10) step(1'b1, 1'b1);
            repeat (12) step(1'b0, 1'b1);
            exp_c = CW'(k);
            exp_n = 2'(k);
            checks++;
            if (q !== k[0] || pulse_cnt !== exp_c || pulse_cnt_n !== exp_n) begin
                errors++;
                $display("FAIL downstream press %0d: got q=%b cnt=%0d cnt2=%0d, want q=%b cnt=%0d cnt2=%0d",
                         k, q, pulse_cnt, pulse_cnt_n, k[0], exp_c, exp_n);
            end
        end
    endtask

    task automatic test_long_hold();
        int            base, seen_pulses;
        logic          exp_p;
        logic [CW-1:0] exp_c;
        settle();
        base = m_total;
        seen_pulses = 0;
        for (int i = 1; i <= 47; i++) begin
            step(1'b1, 1'b1);
`ifdef TOGGLE_AUTOREPEAT_EN
            exp_p = (i == 7 || i == 23 || i == 31 || i == 39 || i == 47);
`else
            exp_p = (i == 7);
`endif
            if (exp_p) seen_pulses++;
            exp_c = CW'(base + seen_pulses);
            checks++;
            if (t_pulse !== exp_p || btn_level !== (i >= 7) || pulse_cnt !== exp_c) begin
                errors++;
                $display("FAIL long_hold edge %0d: got p=%b l=%b cnt=%0d, want p=%b l=%b cnt=%0d",
                         i, t_pulse, btn_level, pulse_cnt, exp_p, (i >= 7), exp_c);
            end
        end
        settle();
    endtask

    task automatic test_random();
        logic b, e;
        int   len, cyc;
        logic [CW-1:0] exp_c;
        b = 1'b0; e = 1'b1; cyc = 0;
        while (cyc < 1500) begin
            b   = ~b;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 50) : $urandom_range(1, 8);
            if (b) e = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < len; j++) begin
                step(b, e);
                cyc++;
                exp_c = CW'(m_total);
                checks++;
                if (t_pulse !== m_pulse || btn_level !== m_level || pulse_cnt !== exp_c ||
                    pulse_cnt_n !== 2'(m_total)) begin
                    errors++;
                    $display("FAIL random cyc %0d: got p=%b l=%b cnt=%0d cnt2=%0d, want p=%b l=%b cnt=%0d cnt2=%0d",
                             cyc, t_pulse, btn_level, pulse_cnt, pulse_cnt_n,
                             m_pulse, m_level, exp_c, 2'(m_total));
                end
            end
        end
        settle();
        checks++;
        if (q !== m_total[0]) begin
            errors++;
            $display("FAIL random_tstage: got q=%b, want q=%b", q, m_total[0]);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_enable_off();
        test_downstream_wrap();
        test_long_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
